// File: rtl/stack_mem_sequencer.sv
// Stack command sequencer: runs PUSH/POP/CALL/RETURN as byte accesses to data memory.
// Ports: clk, rst_n | cmd_valid/cmd_ready/cmd_op/push_data | done, pop_data, jump_valid,
//        err_overflow, err_underflow | mem_addr/mem_we/mem_wdata/mem_rdata | stack_pointer, empty, full
module stack_mem_sequencer #(
    parameter logic [7:0] SP_INIT = 8'h3E,
    parameter logic [7:0] SP_TOP  = 8'h80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] push_data,
    output logic        done,
    output logic [15:0] pop_data,
    output logic        jump_valid,
    output logic        err_overflow,
    output logic        err_underflow,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  stack_pointer,
    output logic        empty,
    output logic        full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_RD_LO,
        S_RD_HI,
        S_RD_CAP,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  sp_q, sp_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [15:0] pop_q, pop_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    assign stack_pointer = sp_q;
    assign empty         = (sp_q == SP_INIT);
    assign full          = (sp_q == SP_TOP);
    assign pop_data      = pop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sp_q    <= SP_INIT;
            op_q    <= 2'd0;
            data_q  <= 16'd0;
            pop_q   <= 16'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            op_q    <= op_d;
            data_q  <= data_d;
            pop_q   <= pop_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        op_d          = op_q;
        data_d        = data_q;
        pop_d         = pop_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        cmd_ready     = 1'b0;
        done          = 1'b0;
        jump_valid    = 1'b0;
        err_overflow  = 1'b0;
        err_underflow = 1'b0;
        mem_addr      = 8'd0;
        mem_we        = 1'b0;
        mem_wdata     = 8'd0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = push_data;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    // bit0 selects read (POP/RETURN) vs write (PUSH/CALL)
                    if (!cmd_op[0]) begin
                        if (full) begin
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WR_LO;
                        end
                    end else begin
                        if (empty) begin
                            unf_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RD_LO;
                        end
                    end
                end
            end
            S_WR_LO: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = data_q[7:0];
                state_d   = S_WR_HI;
            end
            S_WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q + 8'd1;
                mem_wdata = data_q[15:8];
                sp_d      = sp_q + 8'd2;
                state_d   = S_DONE;
            end
            S_RD_LO: begin
                mem_addr = sp_q - 8'd2;
                state_d  = S_RD_HI;
            end
            S_RD_HI: begin
                // read data lags the address by one cycle: this is the low byte
                mem_addr    = sp_q - 8'd1;
                pop_d[7:0]  = mem_rdata;
                state_d     = S_RD_CAP;
            end
            S_RD_CAP: begin
                pop_d[15:8] = mem_rdata;
                sp_d        = sp_q - 8'd2;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done          = 1'b1;
                err_overflow  = ovf_q;
                err_underflow = unf_q;
                jump_valid    = (op_q == 2'd3) && !ovf_q && !unf_q;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
